// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - instruction memory with byte-serial little-endian program loader
// Synchronous fetch read port with write-first bypass; load stops on halt word or full memory.
module inst_mem_loader #(
  parameter int                  NB_DATA    = 32,
  parameter int                  NBYTE      = 8,
  parameter int                  ADDR_W     = 7,
  parameter int                  N_ELEMENTS = 2**ADDR_W,
  parameter logic [NB_DATA-1:0]  HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                load_start_i,
  input  logic                byte_valid_i,
  input  logic [NBYTE-1:0]    byte_i,
  input  logic                en_read_i,
  input  logic [ADDR_W-1:0]   addr_read_i,
  output logic [NB_DATA-1:0]  data_o,
  output logic                loading_o,
  output logic                load_done_o,
  output logic                full_o,
  output logic [ADDR_W:0]     word_count_o
);

  localparam int BPW   = NB_DATA / NBYTE;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEMENTS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NB_DATA-1:0]  buf_q, buf_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                full_q, full_d;
  logic [NB_DATA-1:0]  data_q;
  logic [NB_DATA-1:0]  asm_word;
  logic                commit;

  logic [NB_DATA-1:0]  mem [0:N_ELEMENTS-1];

  // Current byte merged into the partial word so a commit needs no extra cycle
  always_comb begin
    asm_word = buf_q;
    asm_word[int'(idx_q)*NBYTE +: NBYTE] = byte_i;
  end

  assign commit = (state_q == LOAD) && byte_valid_i && (idx_q == LAST_IDX);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      idx_q     <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_start_i) begin
          state_d   = LOAD;
          wr_addr_d = '0;
          idx_d     = '0;
          buf_d     = '0;
          cnt_d     = '0;
          full_d    = 1'b0;
        end
      end
      LOAD: begin
        if (commit) begin
          idx_d = '0;
          buf_d = '0;
          cnt_d = cnt_q + 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_d = DONE;
            full_d  = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (asm_word == HALT_WORD) state_d = DONE;
          end
        end else if (byte_valid_i) begin
          buf_d = asm_word;
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    loading_o    = (state_q == LOAD);
    load_done_o  = (state_q == DONE);
    full_o       = full_q;
    word_count_o = cnt_q;
    data_o       = data_q;
  end

  // RAM has no reset; a commit coinciding with reset is dropped
  always_ff @(posedge clock_i) begin
    if (commit && !reset_i) mem[wr_addr_q] <= asm_word;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (en_read_i) begin
      if (commit && (addr_read_i == wr_addr_q)) data_q <= asm_word;
      else                                      data_q <= mem[addr_read_i];
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - scoreboard bench for inst_mem_loader
module tb_inst_mem_loader;

  localparam int NW = 4;

  logic        clock = 1'b0;
  logic        reset_i = 1'b0;
  logic        load_start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        en_read_i = 1'b0;
  logic [1:0]  addr_read_i = '0;
  logic [31:0] data_o;
  logic        loading_o, load_done_o, full_o;
  logic [2:0]  word_count_o;

  inst_mem_loader #(
    .NB_DATA(32), .NBYTE(8), .ADDR_W(2), .N_ELEMENTS(NW), .HALT_WORD(32'hFFFFFFFF)
  ) dut (
    .clock_i(clock), .reset_i(reset_i), .load_start_i(load_start_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .en_read_i(en_read_i),
    .addr_read_i(addr_read_i), .data_o(data_o), .loading_o(loading_o),
    .load_done_o(load_done_o), .full_o(full_o), .word_count_o(word_count_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    bit          dk;
    bit          loading;
    bit          done;
    bit          full;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: 0 = idle, 1 = loading, 2 = finished
  int          m_phase = 0;
  logic [7:0]  m_bytes[$];
  int          m_wr = 0;
  int          m_cnt = 0;
  bit          m_full = 0;
  logic [31:0] m_data = '0;
  bit          m_dk = 1;
  logic [31:0] ref_mem[NW];
  bit          ref_valid[NW];
  bit          halt_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit bv, input logic [7:0] b,
                      input bit en, input int a);
    logic [31:0] word;
    bit          wrote;
    exp_t        e;
    @(negedge clock);
    reset_i      = r;
    load_start_i = st;
    byte_valid_i = bv;
    byte_i       = b;
    en_read_i    = en;
    addr_read_i  = 2'(a);
    wrote = 0;
    word  = '0;
    if (r) begin
      m_phase = 0; m_bytes.delete(); m_wr = 0; m_cnt = 0; m_full = 0;
      m_data = '0; m_dk = 1;
    end else begin
      if (m_phase == 1 && bv && m_bytes.size() == 3) begin
        wrote = 1;
        for (int i = 0; i < 3; i++) word = word | (32'(m_bytes[i]) << (8 * i));
        word = word | (32'(b) << 24);
      end
      if (en) begin
        if (wrote && a == m_wr) begin m_data = word; m_dk = 1; end
        else if (ref_valid[a])  begin m_data = ref_mem[a]; m_dk = 1; end
        else m_dk = 0;
      end
      if (m_phase != 1 && st) begin
        m_phase = 1; m_bytes.delete(); m_wr = 0; m_cnt = 0; m_full = 0;
      end else if (m_phase == 1 && bv) begin
        if (wrote) begin
          ref_mem[m_wr] = word; ref_valid[m_wr] = 1;
          m_cnt++;
          m_bytes.delete();
          if (m_wr == NW - 1) begin m_phase = 2; m_full = 1; end
          else begin
            m_wr++;
            if (word == 32'hFFFFFFFF) m_phase = 2;
          end
        end else m_bytes.push_back(b);
      end
    end
    e.data = m_data; e.dk = m_dk; e.loading = (m_phase == 1);
    e.done = (m_phase == 2); e.full = m_full; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle_c();
    step(0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit en, input int a);
    for (int i = 0; i < 4; i++) step(0, 0, 1, w[8*i +: 8], en, a);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("loading_o", 32'(loading_o), 32'(e.loading));
        chk("load_done_o", 32'(load_done_o), 32'(e.done));
        chk("full_o", 32'(full_o), 32'(e.full));
        chk("word_count_o", 32'(word_count_o), 32'(e.cnt));
        if (e.dk) chk("data_o", data_o, e.data);
      end
    end
  end

  initial begin : driver
    logic [7:0] b;
    for (int i = 0; i < NW; i++) ref_valid[i] = 0;
    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 1, 1, 8'h55, 1, 0);
    idle_c();
    // first word then read it back
    step(0, 1, 0, 8'h00, 0, 0);
    send_word(32'h20200013, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0);
    idle_c();
    // start mid-load is ignored; halt word terminates
    step(0, 1, 0, 8'h00, 0, 0);
    send_word(32'hFFFFFFFF, 0, 0);
    send_word(32'h44332211, 0, 0);
    step(0, 0, 0, 8'h00, 1, 1);
    step(0, 0, 0, 8'h00, 1, 0);
    // restart from done and fill memory
    step(0, 1, 0, 8'h00, 0, 0);
    for (int w = 0; w < NW; w++) send_word(32'h10203040 + 32'(w), 0, 0);
    step(0, 0, 1, 8'h99, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0);
    step(0, 0, 0, 8'h00, 1, 3);
    // write-first collision on address 0
    step(0, 1, 0, 8'h00, 1, 0);
    send_word(32'hDEADBEEF, 1, 0);
    step(0, 0, 0, 8'h00, 1, 0);
    step(0, 0, 0, 8'h00, 1, 0);
    // reset discards partial word
    send_word(32'h0BADF00D, 0, 0);
    step(0, 0, 1, 8'hAA, 0, 0);
    step(0, 0, 1, 8'hBB, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    send_word(32'h04030201, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0);
    step(0, 0, 0, 8'h00, 1, 2);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_bytes.size() == 0) halt_mode = ($urandom_range(0, 3) == 0);
      b = halt_mode ? 8'hFF : 8'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, b, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, NW - 1)));
    end
    idle_c();
    idle_c();
    @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
